// File: rtl/control_multiciclo.sv
// control_multiciclo: main control FSM for the multicycle MIPS datapath.
// It steps each instruction through fetch, decode, execute, memory access and
// write-back, and drives the datapath enables and mux/ALU selects. Outputs
// depend only on the current state. The exceptions are PCEn, the mem_ready
// gating in FETCH, and the illegal-opcode flag raised in DECODE.
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   Op              opcode field IR[31:26]
//   Zero            ALU zero flag
//   mem_ready       memory finished the current access this cycle
//   PCWrite, PCEn, Branch, IorD, MemRead, MemWrite, IRWrite, RegDst,
//   MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSrc
//                   datapath controls
//   illegal         one-cycle pulse in DECODE for an unsupported opcode
//   state           current state encoding (debug)
//   instr_count     retired-instruction counter, wraps modulo 2^CNT_W
module control_multiciclo #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       Op,
  input  logic             Zero,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCEn,
  output logic             Branch,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             RegDst,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSrc,
  output logic             illegal,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              retire;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Retired-instruction counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count_d     = retire ? count_q + CNT_W'(1) : count_q;
  assign state       = state_q;
  assign instr_count = count_q;

  // Next-state and output decode
  always_comb begin
    state_d  = state_q;
    retire   = 1'b0;
    PCWrite  = 1'b0;
    PCEn     = 1'b0;
    Branch   = 1'b0;
    IorD     = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    RegDst   = 1'b0;
    MemtoReg = 1'b0;
    RegWrite = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'b00;
    ALUOp    = 2'b00;
    PCSrc    = 2'b00;
    illegal  = 1'b0;

    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        case (Op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEXEC;
          OP_J:         state_d = S_JUMP;
          default: begin
            state_d = S_FETCH;
            illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = (Op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMWRITE: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXECUTE: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b01;
        PCSrc   = 2'b01;
        Branch  = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_ADDIEXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: begin
        RegWrite = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_JUMP: begin
        PCSrc   = 2'b10;
        PCWrite = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;  // unused codes 12-15 recover to FETCH
    endcase

    PCEn = PCWrite | (Branch & Zero);

    // While rst is high, every control output is held at 0, so nothing is
    // written even though the state decodes as FETCH.
    if (rst) begin
      PCWrite  = 1'b0;
      PCEn     = 1'b0;
      Branch   = 1'b0;
      IorD     = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      IRWrite  = 1'b0;
      RegDst   = 1'b0;
      MemtoReg = 1'b0;
      RegWrite = 1'b0;
      ALUSrcA  = 1'b0;
      ALUSrcB  = 2'b00;
      ALUOp    = 2'b00;
      PCSrc    = 2'b00;
      illegal  = 1'b0;
    end
  end

endmodule

// File: tb/tb_control_multiciclo.sv
// Directed testbench for control_multiciclo (counter width 4 so wrap is reachable).
module tb_control_multiciclo;

  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [5:0]       Op;
  logic             Zero;
  logic             mem_ready;
  logic             PCWrite, PCEn, Branch, IorD, MemRead, MemWrite, IRWrite;
  logic             RegDst, MemtoReg, RegWrite, ALUSrcA, illegal;
  logic [1:0]       ALUSrcB, ALUOp, PCSrc;
  logic [3:0]       state;
  logic [CNT_W-1:0] instr_count;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  control_multiciclo #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .Op(Op), .Zero(Zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCEn(PCEn), .Branch(Branch), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc),
    .illegal(illegal), .state(state), .instr_count(instr_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Advance one clock; sample 2 time units after the rising edge
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1; Op = 6'b0; Zero = 1'b0; mem_ready = 1'b1;
    tick(); tick();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_memread", 32'(MemRead), 32'd0);
    chk("rst_alusrcb", 32'(ALUSrcB), 32'd0);
    chk("rst_irwrite", 32'(IRWrite), 32'd0);
    chk("rst_count", 32'(instr_count), 32'd0);

    // Release: FETCH with memory ready
    rst = 1'b0; #1;
    chk("fetch_irwrite", 32'(IRWrite), 32'd1);
    chk("fetch_pcwrite", 32'(PCWrite), 32'd1);
    chk("fetch_pcen", 32'(PCEn), 32'd1);
    chk("fetch_alusrcb", 32'(ALUSrcB), 32'd1);
    chk("fetch_memread", 32'(MemRead), 32'd1);

    // R-type: 0,1,6,7,0
    Op = 6'b000000;
    tick(); chk("r_s1", 32'(state), 32'd1);
    chk("r_dec_alusrcb", 32'(ALUSrcB), 32'd3);
    tick(); chk("r_s6", 32'(state), 32'd6);
    chk("r_exec_aluop", 32'(ALUOp), 32'd2);
    chk("r_exec_regwrite", 32'(RegWrite), 32'd0);
    tick(); chk("r_s7", 32'(state), 32'd7);
    chk("r_wb_regwrite", 32'(RegWrite), 32'd1);
    chk("r_wb_regdst", 32'(RegDst), 32'd1);
    chk("r_wb_count", 32'(instr_count), 32'd0);
    tick(); chk("r_s0", 32'(state), 32'd0);
    chk("r_count", 32'(instr_count), 32'd1);

    // lw with 2 stall cycles in MEMREAD: 0,1,2,3,3,3,4,0
    Op = 6'b100011;
    tick(); chk("lw_s1", 32'(state), 32'd1);
    tick(); chk("lw_s2", 32'(state), 32'd2);
    chk("lw_adr_alusrcb", 32'(ALUSrcB), 32'd2);
    chk("lw_adr_alusrca", 32'(ALUSrcA), 32'd1);
    mem_ready = 1'b0;
    tick(); chk("lw_s3a", 32'(state), 32'd3);
    chk("lw_memread_a", 32'(MemRead), 32'd1);
    chk("lw_iord", 32'(IorD), 32'd1);
    tick(); chk("lw_s3b", 32'(state), 32'd3);
    chk("lw_memread_b", 32'(MemRead), 32'd1);
    tick(); chk("lw_s3c", 32'(state), 32'd3);
    chk("lw_memread_c", 32'(MemRead), 32'd1);
    mem_ready = 1'b1;
    tick(); chk("lw_s4", 32'(state), 32'd4);
    chk("lw_regwrite", 32'(RegWrite), 32'd1);
    chk("lw_memtoreg", 32'(MemtoReg), 32'd1);
    chk("lw_regdst", 32'(RegDst), 32'd0);
    tick(); chk("lw_s0", 32'(state), 32'd0);
    chk("lw_count", 32'(instr_count), 32'd2);

    // FETCH stall: no IR/PC write, MemRead held
    mem_ready = 1'b0; #1;
    chk("fstall_irwrite", 32'(IRWrite), 32'd0);
    chk("fstall_pcwrite", 32'(PCWrite), 32'd0);
    chk("fstall_memread", 32'(MemRead), 32'd1);
    tick(); chk("fstall_s0", 32'(state), 32'd0);
    mem_ready = 1'b1;

    // sw with one stall in MEMWRITE
    Op = 6'b101011;
    tick(); chk("sw_s1", 32'(state), 32'd1);
    tick(); chk("sw_s2", 32'(state), 32'd2);
    mem_ready = 1'b0;
    tick(); chk("sw_s5", 32'(state), 32'd5);
    chk("sw_memwrite", 32'(MemWrite), 32'd1);
    chk("sw_regwrite", 32'(RegWrite), 32'd0);
    tick(); chk("sw_s5_hold", 32'(state), 32'd5);
    chk("sw_memwrite_hold", 32'(MemWrite), 32'd1);
    chk("sw_count_hold", 32'(instr_count), 32'd2);
    mem_ready = 1'b1;
    tick(); chk("sw_s0", 32'(state), 32'd0);
    chk("sw_count", 32'(instr_count), 32'd3);

    // beq: PCEn follows Zero in BRANCH
    Op = 6'b000100;
    tick(); chk("beq_s1", 32'(state), 32'd1);
    Zero = 1'b1;
    tick(); chk("beq_s8", 32'(state), 32'd8);
    chk("beq_pcen_z1", 32'(PCEn), 32'd1);
    chk("beq_pcsrc", 32'(PCSrc), 32'd1);
    chk("beq_aluop", 32'(ALUOp), 32'd1);
    Zero = 1'b0; #1;
    chk("beq_pcen_z0", 32'(PCEn), 32'd0);
    chk("beq_branch", 32'(Branch), 32'd1);
    tick(); chk("beq_s0", 32'(state), 32'd0);
    chk("beq_count", 32'(instr_count), 32'd4);

    // addi: 0,1,9,10,0
    Op = 6'b001000;
    tick(); chk("addi_s1", 32'(state), 32'd1);
    tick(); chk("addi_s9", 32'(state), 32'd9);
    chk("addi_alusrcb", 32'(ALUSrcB), 32'd2);
    tick(); chk("addi_s10", 32'(state), 32'd10);
    chk("addi_regwrite", 32'(RegWrite), 32'd1);
    chk("addi_memtoreg", 32'(MemtoReg), 32'd0);
    tick(); chk("addi_s0", 32'(state), 32'd0);
    chk("addi_count", 32'(instr_count), 32'd5);

    // Illegal opcode
    Op = 6'b111111;
    tick(); chk("ill_s1", 32'(state), 32'd1);
    chk("ill_pulse", 32'(illegal), 32'd1);
    chk("ill_regwrite", 32'(RegWrite), 32'd0);
    chk("ill_memwrite", 32'(MemWrite), 32'd0);
    tick(); chk("ill_s0", 32'(state), 32'd0);
    chk("ill_pulse_off", 32'(illegal), 32'd0);
    chk("ill_count", 32'(instr_count), 32'd5);

    // Reset asserted mid-instruction (in EXECUTE)
    Op = 6'b000000;
    tick(); tick(); chk("abort_pre_s6", 32'(state), 32'd6);
    rst = 1'b1; #1;
    chk("abort_state", 32'(state), 32'd0);
    chk("abort_memread", 32'(MemRead), 32'd0);
    chk("abort_pcwrite", 32'(PCWrite), 32'd0);
    chk("abort_count", 32'(instr_count), 32'd0);
    tick(); chk("abort_regwrite", 32'(RegWrite), 32'd0);
    rst = 1'b0;

    // 16 jumps wrap the 4-bit counter back to 0
    Op = 6'b000010;
    for (int i = 0; i < 16; i++) begin
      tick(); chk("j_s1", 32'(state), 32'd1);
      tick(); chk("j_s11", 32'(state), 32'd11);
      chk("j_pcwrite", 32'(PCWrite), 32'd1);
      chk("j_pcsrc", 32'(PCSrc), 32'd2);
      tick(); chk("j_count", 32'(instr_count), 32'((i + 1) % 16));
    end
    chk("j_wrap", 32'(instr_count), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
